display_timings_rx: RTL and testbench

//  Receive-side counterpart of our display timing generator. Takes incoming hs/vs/de
//  (e.g. from a video input or a generator under test) in the pixel clock domain.

---
 rtl/display_timings_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_display_timings_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timings_rx.sv
// Video timing receiver: measures incoming hs/vs/de and regenerates pixel coordinates.
// Define DISPLAY_TIMINGS_RX_SYNCW_EN to also measure hsync/vsync widths.
module display_timings_rx #(
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int CW          = 13,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          i_pixclk,
  input  logic          i_rst_n,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          i_de,
  output logic          o_de,
  output logic [CW-1:0] o_h,
  output logic [CW-1:0] o_v,
  output logic          o_frame,
  output logic          o_locked,
  output logic [CW-1:0] o_line,
  output logic [CW-1:0] o_frame_len,
  output logic [CW-1:0] o_h_res,
  output logic [CW-1:0] o_v_res,
  output logic [CW-1:0] o_hsync_w,
  output logic [CW-1:0] o_vsync_w
);

  localparam int MW =
    (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    LOCKED
  } state_t;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] x
  );
    return (x == CMAX) ? x : x + 1'b1;
  endfunction

  logic hs, vs, hs_q, vs_q;
  logic hs_rise, vs_rise, de_fall;

  assign hs = H_POL ? i_hs : ~i_hs;
  assign vs = V_POL ? i_vs : ~i_vs;
  assign hs_rise = hs & ~hs_q;
  assign vs_rise = vs & ~vs_q;
  assign de_fall = o_de & ~i_de;

  logic [CW-1:0] pcnt, lcnt;

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      o_de    <= 1'b0;
      pcnt    <= '0;
      lcnt    <= '0;
      o_h     <= '0;
      o_v     <= '0;
      o_frame <= 1'b0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      o_de    <= i_de;
      pcnt    <= i_de ? pcnt + 1'b1 : '0;
      o_h     <= i_de ? pcnt : '0;
      o_v     <= i_de ? lcnt : '0;
      o_frame <= i_de && pcnt == '0 && lcnt == '0;
      if (vs_rise)
        lcnt <= '0;
      else if (de_fall)
        lcnt <= lcnt + 1'b1;
    end
  end

  logic [CW-1:0] hcnt, dcnt, ref_len, h_act;
  logic [CW-1:0] vlines, vact;
  logic          first, h_seen, bad;
  logic [CW-1:0] line_len, ref_nx, hact_nx;
  logic [CW-1:0] vlines_nx, vact_nx;
  logic          len_bad, act_bad, bad_nx, has_de;

  assign line_len  = sat_inc(hcnt);
  assign has_de    = dcnt != '0;
  assign len_bad   = !first && line_len != ref_len;
  assign act_bad   = has_de && h_seen && dcnt != h_act;
  assign bad_nx    = bad | (hs_rise & (len_bad | act_bad));
  assign ref_nx    = (hs_rise && first) ? line_len : ref_len;
  assign hact_nx   = (hs_rise && has_de) ? dcnt : h_act;
  assign vlines_nx = hs_rise ? sat_inc(vlines) : vlines;
  assign vact_nx   =
    (hs_rise && has_de) ? sat_inc(vact) : vact;

  // hs rise coincident with vs rise is folded into the ending frame
  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt        <= '0;
      dcnt        <= '0;
      ref_len     <= '0;
      h_act       <= '0;
      vlines      <= '0;
      vact        <= '0;
      first       <= 1'b1;
      h_seen      <= 1'b0;
      bad         <= 1'b0;
      o_line      <= '0;
      o_frame_len <= '0;
      o_h_res     <= '0;
      o_v_res     <= '0;
    end else begin
      hcnt    <= hs_rise ? '0 : sat_inc(hcnt);
      ref_len <= ref_nx;
      h_act   <= hact_nx;
      if (hs_rise)
        dcnt <= CW'(i_de);
      else if (i_de)
        dcnt <= sat_inc(dcnt);
      if (vs_rise) begin
        o_line      <= ref_nx;
        o_h_res     <= hact_nx;
        o_frame_len <= vlines_nx;
        o_v_res     <= vact_nx;
        vlines      <= '0;
        vact        <= '0;
        bad         <= 1'b0;
        first       <= 1'b1;
        h_seen      <= 1'b0;
      end else begin
        vlines <= vlines_nx;
        vact   <= vact_nx;
        bad    <= bad_nx;
        if (hs_rise)
          first <= 1'b0;
        if (hs_rise && has_de)
          h_seen <= 1'b1;
      end
    end
  end

  state_t        state, state_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic          fresh, fresh_nx;
  logic          snap_ok, snap_eq, timeout;

  assign snap_ok = !bad_nx && ref_nx != '0 &&
    hact_nx != '0 && vlines_nx != '0 && vact_nx != '0;
  assign snap_eq =
    {ref_nx, hact_nx, vlines_nx, vact_nx} ==
    {o_line, o_h_res, o_frame_len, o_v_res};
  assign timeout =
    (hcnt == CMAX && !hs_rise) || vlines == CMAX;

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      fresh     <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      fresh     <= fresh_nx;
    end
  end

  // first frame after IDLE has nothing to compare against and opens the run
  always_comb begin
    state_nx = state;
    match_nx = match_cnt;
    fresh_nx = fresh;
    if (timeout) begin
      state_nx = IDLE;
      match_nx = '0;
      fresh_nx = 1'b0;
    end else if (vs_rise) begin
      fresh_nx = 1'b0;
      unique case (state)
        IDLE: begin
          state_nx = MEAS;
          match_nx = '0;
          fresh_nx = 1'b1;
        end
        MEAS: begin
          if (snap_ok && (fresh || snap_eq))
            match_nx = match_cnt + 1'b1;
          else
            match_nx = '0;
          if (match_nx == LOCK_N)
            state_nx = LOCKED;
        end
        LOCKED: begin
          if (!(snap_ok && snap_eq)) begin
            state_nx = MEAS;
            match_nx = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          match_nx = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_locked = (state == LOCKED);
  end

`ifdef DISPLAY_TIMINGS_RX_SYNCW_EN
  logic [CW-1:0] hsw_cnt, vsw_cnt;
  logic          hs_fall, vs_fall;

  assign hs_fall = ~hs & hs_q;
  assign vs_fall = ~vs & vs_q;

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsw_cnt   <= '0;
      vsw_cnt   <= '0;
      o_hsync_w <= '0;
      o_vsync_w <= '0;
    end else begin
      if (hs_rise)
        hsw_cnt <= CW'(1);
      else if (hs)
        hsw_cnt <= sat_inc(hsw_cnt);
      if (hs_fall)
        o_hsync_w <= hsw_cnt;
      if (vs_rise)
        vsw_cnt <= CW'(hs_rise);
      else if (vs && hs_rise)
        vsw_cnt <= sat_inc(vsw_cnt);
      if (vs_fall)
        o_vsync_w <= vsw_cnt;
    end
  end
`else
  assign o_hsync_w = '0;
  assign o_vsync_w = '0;
`endif

endmodule

// File: tb/tb_display_timings_rx.sv
// Directed bench for display_timings_rx using two small scaled video modes.
// Mode 0: 24x10 total, 16x6 active; mode 1: 30x12 total, 20x7 active.
module tb_display_timings_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        de_in = 1'b0;
  logic        o_de, o_frame, o_locked;
  logic [12:0] o_h, o_v, o_line, o_frame_len;
  logic [12:0] o_h_res, o_v_res, o_hsync_w, o_vsync_w;

  display_timings_rx dut (
    .i_pixclk    (clk),
    .i_rst_n     (rst_n),
    .i_hs        (hs_in),
    .i_vs        (vs_in),
    .i_de        (de_in),
    .o_de        (o_de),
    .o_h         (o_h),
    .o_v         (o_v),
    .o_frame     (o_frame),
    .o_locked    (o_locked),
    .o_line      (o_line),
    .o_frame_len (o_frame_len),
    .o_h_res     (o_h_res),
    .o_v_res     (o_v_res),
    .o_hsync_w   (o_hsync_w),
    .o_vsync_w   (o_vsync_w)
  );

  int ht [2] = '{24, 30};
  int hw [2] = '{3, 4};
  int hb [2] = '{2, 2};
  int ha [2] = '{16, 20};
  int vt [2] = '{10, 12};
  int vw [2] = '{2, 3};
  int vb [2] = '{1, 1};
  int va [2] = '{6, 7};

  int checks = 0;
  int errors = 0;

  logic        pix_chk = 1'b0;
  logic        p_de = 1'b0;
  logic        p_f = 1'b0;
  logic [12:0] p_h = '0;
  logic [12:0] p_v = '0;
  int          nframes;
  logic [12:0] last_h, last_v;

  task automatic tick(input logic h, input logic v,
                      input logic d, input logic [12:0] eh,
                      input logic [12:0] ev, input logic ef);
    @(negedge clk);
    if (pix_chk) begin
      checks++;
      if ({o_de, o_h, o_v, o_frame} !==
          {p_de, p_h, p_v, p_f}) begin
        errors++;
        $display("FAIL pixel: got de=%b h=%0d v=%0d f=%b want de=%b h=%0d v=%0d f=%b",
                 o_de, o_h, o_v, o_frame, p_de, p_h, p_v, p_f);
      end
      if (o_frame) nframes++;
      if (o_de) begin
        last_h = o_h;
        last_v = o_v;
      end
    end
    hs_in = h;
    vs_in = v;
    de_in = d;
    p_de  = d;
    p_h   = eh;
    p_v   = ev;
    p_f   = ef;
  endtask

  task automatic drive_frame(input int m, input int c0,
                             input int c1);
    int x, y, hs0, vs0;
    logic a;
    hs0 = hw[m] + hb[m];
    vs0 = vw[m] + vb[m];
    for (int c = c0; c < c1; c++) begin
      x = c % ht[m];
      y = c / ht[m];
      a = x >= hs0 && x < hs0 + ha[m] &&
          y >= vs0 && y < vs0 + va[m];
      tick(!(x < hw[m]), !(y < vw[m]), a,
           a ? 13'(x - hs0) : 13'd0,
           a ? 13'(y - vs0) : 13'd0,
           a && x == hs0 && y == vs0);
    end
  endtask

  task automatic frames(input int m, input int n);
    for (int i = 0; i < n; i++)
      drive_frame(m, 0, ht[m] * vt[m]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b1, 1'b1, 1'b0, 13'd0, 13'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_de, o_h, o_v, o_frame, o_locked, o_line,
         o_frame_len, o_h_res, o_v_res, o_hsync_w,
         o_vsync_w} !== '0) begin
      errors++;
      $display("FAIL reset_state: got nonzero outputs, want 0");
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_lock();
    frames(0, 2);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: got %b want 0", o_locked);
    end
    checks++;
    if ({o_line, o_frame_len, o_h_res, o_v_res} !==
        {13'd24, 13'd10, 13'd16, 13'd6}) begin
      errors++;
      $display("FAIL snap_mode0: got %0d %0d %0d %0d want 24 10 16 6",
               o_line, o_frame_len, o_h_res, o_v_res);
    end
    frames(0, 1);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_third_vs: got %b want 1", o_locked);
    end
  endtask

  task automatic test_pixel();
    nframes = 0;
    last_h  = '0;
    last_v  = '0;
    pix_chk = 1'b1;
    frames(0, 1);
    pix_chk = 1'b0;
    checks++;
    if (nframes != 1) begin
      errors++;
      $display("FAIL frame_pulses: got %0d want 1", nframes);
    end
    checks++;
    if (last_h !== 13'd15 || last_v !== 13'd5) begin
      errors++;
      $display("FAIL last_pixel: got h=%0d v=%0d want h=15 v=5",
               last_h, last_v);
    end
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold: got %b want 1", o_locked);
    end
  endtask

  task automatic test_mode_change();
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL chg_first: got %b want 1", o_locked);
    end
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL chg_unlock: got %b want 0", o_locked);
    end
    checks++;
    if ({o_line, o_frame_len, o_h_res, o_v_res} !==
        {13'd30, 13'd12, 13'd20, 13'd7}) begin
      errors++;
      $display("FAIL snap_mode1: got %0d %0d %0d %0d want 30 12 20 7",
               o_line, o_frame_len, o_h_res, o_v_res);
    end
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL chg_wait: got %b want 0", o_locked);
    end
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL chg_relock: got %b want 1", o_locked);
    end
  endtask

  task automatic test_timeout();
    idle(8300);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_unlock: got %b want 0", o_locked);
    end
    checks++;
    if ({o_line, o_frame_len, o_h_res, o_v_res} !==
        {13'd30, 13'd12, 13'd20, 13'd7}) begin
      errors++;
      $display("FAIL timeout_hold: got %0d %0d %0d %0d want 30 12 20 7",
               o_line, o_frame_len, o_h_res, o_v_res);
    end
    frames(1, 2);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: got %b want 0", o_locked);
    end
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL restart_lock: got %b want 1", o_locked);
    end
  endtask

  task automatic test_rst_mid();
    drive_frame(1, 0, 100);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_lock: got %b want 1", o_locked);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_de, o_h, o_v, o_frame, o_locked, o_line,
         o_frame_len, o_h_res, o_v_res, o_hsync_w,
         o_vsync_w} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got nonzero outputs, want 0");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_frame(1, 100, ht[1] * vt[1]);
    frames(1, 2);
    checks++;
    if (o_locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_early: got %b want 0", o_locked);
    end
    frames(1, 1);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL rst_relock: got %b want 1", o_locked);
    end
    checks++;
    if ({o_line, o_frame_len, o_h_res, o_v_res} !==
        {13'd30, 13'd12, 13'd20, 13'd7}) begin
      errors++;
      $display("FAIL rst_snap: got %0d %0d %0d %0d want 30 12 20 7",
               o_line, o_frame_len, o_h_res, o_v_res);
    end
  endtask

  task automatic test_syncw();
    logic [12:0] eh1, ev1, eh0, ev0;
`ifdef DISPLAY_TIMINGS_RX_SYNCW_EN
    eh1 = 13'd4;
    ev1 = 13'd3;
    eh0 = 13'd3;
    ev0 = 13'd2;
`else
    eh1 = 13'd0;
    ev1 = 13'd0;
    eh0 = 13'd0;
    ev0 = 13'd0;
`endif
    checks++;
    if (o_hsync_w !== eh1 || o_vsync_w !== ev1) begin
      errors++;
      $display("FAIL syncw_mode1: got %0d %0d want %0d %0d",
               o_hsync_w, o_vsync_w, eh1, ev1);
    end
    frames(0, 1);
    checks++;
    if (o_hsync_w !== eh0 || o_vsync_w !== ev0) begin
      errors++;
      $display("FAIL syncw_mode0: got %0d %0d want %0d %0d",
               o_hsync_w, o_vsync_w, eh0, ev0);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_mode_change();
    test_timeout();
    test_rst_mid();
    test_syncw();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
